// File: rtl/imem_loader.sv
// ============================================================================
// Module   : imem_loader
// Summary  : Boot-time loader that assembles a length-prefixed byte stream into
//            little-endian words and holds the CPU in reset until complete.
//            Optional trailing XOR checksum: define IMEM_LOADER_CHECKSUM_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module imem_loader #(
    parameter int DEPTH_BYTES = 1024,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  start_i,
    input  logic [7:0]            byte_i,
    input  logic                  byte_valid_i,
    output logic                  byte_ready_o,
    output logic                  wr_en_o,
    output logic [ADDR_WIDTH-1:0] wr_addr_o,
    output logic [31:0]           wr_data_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  error_o,
    output logic                  cpu_hold_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_LO = 3'd1,
        S_LEN_HI = 3'd2,
        S_DATA   = 3'd3,
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHK    = 3'd4,
`endif
        S_DONE   = 3'd5,
        S_ERR    = 3'd6
    } state_t;

    localparam logic [31:0] c_depth = 32'(DEPTH_BYTES);

    state_t                r_state;
    state_t                w_next;
    logic [7:0]            r_len_lo;
    logic [15:0]           r_len;
    logic [15:0]           r_cnt;
    logic [23:0]           r_asm;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_wr_en;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [31:0]           r_wr_data;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]            r_csum;
`endif

    logic        w_in_session;
    logic        w_accept;
    logic [15:0] w_len_full;
    logic        w_len_bad;
    logic [15:0] w_cnt_nxt;
    logic        w_word_done;
    logic        w_payload_end;

    // Ready is a pure state decode, so the handshake never depends on byte_valid_i.
    assign w_in_session  = (r_state == S_LEN_LO) || (r_state == S_LEN_HI) ||
`ifdef IMEM_LOADER_CHECKSUM_EN
                           (r_state == S_CHK) ||
`endif
                           (r_state == S_DATA);
    assign w_accept      = byte_valid_i && w_in_session;
    assign w_len_full    = {byte_i, r_len_lo};
    assign w_len_bad     = ({16'd0, w_len_full} > c_depth) || (w_len_full[1:0] != 2'b00);
    assign w_cnt_nxt     = r_cnt + 16'd1;
    assign w_word_done   = w_accept && (r_state == S_DATA) && (r_cnt[1:0] == 2'b11);
    assign w_payload_end = w_word_done && (w_cnt_nxt == r_len);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        byte_ready_o = w_in_session;
        busy_o       = w_in_session;
        done_o       = (r_state == S_DONE);
        error_o      = (r_state == S_ERR);
        cpu_hold_o   = (r_state != S_DONE);
        case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start_i) begin
                    w_next = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (w_accept) begin
                    w_next = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (w_accept) begin
                    if (w_len_bad) begin
                        w_next = S_ERR;
                    end else if (w_len_full == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        w_next = S_CHK;
`else
                        w_next = S_DONE;
`endif
                    end else begin
                        w_next = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (w_payload_end) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    w_next = S_CHK;
`else
                    w_next = S_DONE;
`endif
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHK: begin
                if (w_accept) begin
                    w_next = (byte_i == r_csum) ? S_DONE : S_ERR;
                end
            end
`endif
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_len_lo  <= 8'd0;
            r_len     <= 16'd0;
            r_cnt     <= 16'd0;
            r_asm     <= 24'd0;
            r_addr    <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= 32'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_csum    <= 8'd0;
`endif
        end else begin
            r_wr_en <= 1'b0;
            if (start_i && !w_in_session) begin
                r_cnt     <= 16'd0;
                r_addr    <= '0;
                r_wr_addr <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                r_csum    <= 8'd0;
`endif
            end
            if (w_accept) begin
                case (r_state)
                    S_LEN_LO: r_len_lo <= byte_i;
                    S_LEN_HI: r_len    <= w_len_full;
                    S_DATA: begin
                        r_cnt <= w_cnt_nxt;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        r_csum <= r_csum ^ byte_i;
`endif
                        case (r_cnt[1:0])
                            2'd0: r_asm[7:0]   <= byte_i;
                            2'd1: r_asm[15:8]  <= byte_i;
                            2'd2: r_asm[23:16] <= byte_i;
                            default: begin
                                // Lane 3 completes the word; publish it with its address.
                                r_wr_en   <= 1'b1;
                                r_wr_data <= {byte_i, r_asm};
                                r_wr_addr <= r_addr;
                                r_addr    <= r_addr + ADDR_WIDTH'(4);
                            end
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end

    assign wr_en_o   = r_wr_en;
    assign wr_addr_o = r_wr_addr;
    assign wr_data_o = r_wr_data;

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// ============================================================================
// Module   : tb_imem_loader
// Summary  : Self-checking bench for imem_loader (table, random and hand sequences).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_imem_loader;

    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  byte_d = 8'd0;
    logic        byte_valid = 1'b0;
    logic        byte_ready_o;
    logic        wr_en_o;
    logic [31:0] wr_addr_o;
    logic [31:0] wr_data_o;
    logic        busy_o;
    logic        done_o;
    logic        error_o;
    logic        cpu_hold_o;

    imem_loader #(.DEPTH_BYTES(DEPTH), .ADDR_WIDTH(32)) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .start_i      (start),
        .byte_i       (byte_d),
        .byte_valid_i (byte_valid),
        .byte_ready_o (byte_ready_o),
        .wr_en_o      (wr_en_o),
        .wr_addr_o    (wr_addr_o),
        .wr_data_o    (wr_data_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .error_o      (error_o),
        .cpu_hold_o   (cpu_hold_o)
    );

    always #5 clk = ~clk;

    typedef logic [7:0] bq_t[$];

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] got_addr[$];
    logic [31:0] got_data[$];
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];

    always @(negedge clk) begin
        if (wr_en_o) begin
            got_addr.push_back(wr_addr_o);
            got_data.push_back(wr_data_o);
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Present one byte, optionally after idle gap cycles, and return #1 after its accepting edge.
    task automatic send_byte(input logic [7:0] b, input int gap, input bit poke_start);
        int  waited;
        bit  ok;
        waited = 0;
        ok = 1'b0;
        byte_valid = 1'b0;
        repeat (gap) tick();
        byte_d = b;
        byte_valid = 1'b1;
        start = poke_start;
        while (!ok && waited <= 40) begin
            @(negedge clk);
            if (byte_ready_o) ok = 1'b1;
            else waited++;
        end
        if (!ok) begin
            check("ready_timeout", 64'd0, 64'd1);
        end else begin
            @(posedge clk);
            #1;
        end
        byte_valid = 1'b0;
        start = 1'b0;
    endtask

    function automatic bit len_ok(input int len);
        return (len <= DEPTH) && (len % 4 == 0);
    endfunction

    function automatic logic [7:0] xor_payload(input bq_t s, input int len);
        logic [7:0] x = 8'h00;
        for (int i = 0; i < len; i++) x ^= s[2+i];
        return x;
    endfunction

    // Reference: split the payload into little-endian words at 4*index.
    task automatic model(input bq_t s, output bit exp_err);
        int len;
        exp_addr.delete();
        exp_data.delete();
        len = int'({s[1], s[0]});
        exp_err = 1'b0;
        if (!len_ok(len)) begin
            exp_err = 1'b1;
        end else begin
            for (int w = 0; w < len / 4; w++) begin
                exp_addr.push_back(32'(4 * w));
                exp_data.push_back({s[2+4*w+3], s[2+4*w+2], s[2+4*w+1], s[2+4*w]});
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            exp_err = (s[2+len] != xor_payload(s, len));
`endif
        end
    endtask

    function automatic bq_t make_stream(input logic [15:0] len, input bit good_chk);
        bq_t s;
        s.push_back(len[7:0]);
        s.push_back(len[15:8]);
        if (len_ok(int'(len))) begin
            for (int i = 0; i < int'(len); i++) s.push_back(8'($urandom));
`ifdef IMEM_LOADER_CHECKSUM_EN
            s.push_back(good_chk ? xor_payload(s, int'(len))
                                 : xor_payload(s, int'(len)) ^ 8'(1 + $urandom_range(0, 254)));
`endif
        end
        return s;
    endfunction

    // gap < 0 selects random gaps of 0..2 cycles per byte.
    task automatic run_session(input bq_t s, input int gap, input bit poke, input string tag);
        bit exp_err;
        int len;
        len = int'({s[1], s[0]});
        got_addr.delete();
        got_data.delete();
        do_start();
        check({tag, "_busy_after_start"}, 64'(busy_o), 64'd1);
        for (int i = 0; i < s.size(); i++) begin
            send_byte(s[i], (gap < 0) ? $urandom_range(0, 2) : gap,
                      poke && ($urandom_range(0, 7) == 0));
            if (i == 1 && !len_ok(len)) check({tag, "_err_on_len_edge"}, 64'(error_o), 64'd1);
`ifndef IMEM_LOADER_CHECKSUM_EN
            if (i == 1 && len == 0) check({tag, "_done_on_len0_edge"}, 64'(done_o), 64'd1);
`endif
        end
        repeat (3) tick();
        model(s, exp_err);
        check({tag, "_nwrites"}, 64'(got_addr.size()), 64'(exp_addr.size()));
        for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
            check({tag, "_addr"}, 64'(got_addr[i]), 64'(exp_addr[i]));
            check({tag, "_data"}, 64'(got_data[i]), 64'(exp_data[i]));
        end
        check({tag, "_done"}, 64'(done_o), 64'(!exp_err));
        check({tag, "_error"}, 64'(error_o), 64'(exp_err));
        check({tag, "_cpu_hold"}, 64'(cpu_hold_o), 64'(exp_err));
        check({tag, "_idle_busy"}, 64'(busy_o), 64'd0);
        check({tag, "_idle_ready"}, 64'(byte_ready_o), 64'd0);
    endtask

    typedef struct {
        logic [15:0] len;
        int          gap;
        bit          exp_err;
        int          exp_words;
    } vec_t;

    vec_t vecs[10];
    bq_t  plan;

    initial begin
        vecs[0] = '{16'h0008, 0, 1'b0, 2};
        vecs[1] = '{16'h0006, 0, 1'b1, 0};
        vecs[2] = '{16'h0404, 0, 1'b1, 0};
        vecs[3] = '{16'h0000, 0, 1'b0, 0};
        vecs[4] = '{16'h0400, 0, 1'b0, 256};
        vecs[5] = '{16'h0401, 0, 1'b1, 0};
        vecs[6] = '{16'h0003, 0, 1'b1, 0};
        vecs[7] = '{16'h0010, 2, 1'b0, 4};
        vecs[8] = '{16'h03FC, 1, 1'b0, 255};
        vecs[9] = '{16'h8000, 0, 1'b1, 0};
        plan = '{8'h08, 8'h00, 8'h03, 8'h21, 8'h40, 8'h00, 8'h83, 8'h01, 8'h40, 8'h00};
`ifdef IMEM_LOADER_CHECKSUM_EN
        plan.push_back(8'hA0);
`endif

        // Reset state
        #12;
        check("rst_ready", 64'(byte_ready_o), 64'd0);
        check("rst_wr_en", 64'(wr_en_o), 64'd0);
        check("rst_wr_addr", 64'(wr_addr_o), 64'd0);
        check("rst_wr_data", 64'(wr_data_o), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_done", 64'(done_o), 64'd0);
        check("rst_error", 64'(error_o), 64'd0);
        check("rst_cpu_hold", 64'(cpu_hold_o), 64'd1);
        rst_n = 1'b1;
        tick();

        // Example image: write timing and contents checked against hand-computed words
        got_addr.delete();
        got_data.delete();
        do_start();
        for (int i = 0; i < 10; i++) send_byte(plan[i], 0, 1'b0);
        check("plan_last_wr_en", 64'(wr_en_o), 64'd1);
`ifdef IMEM_LOADER_CHECKSUM_EN
        check("plan_done_before_chk", 64'(done_o), 64'd0);
        check("plan_busy_in_chk", 64'(busy_o), 64'd1);
        send_byte(plan[10], 0, 1'b0);
`endif
        check("plan_done_edge", 64'(done_o), 64'd1);
        check("plan_hold_edge", 64'(cpu_hold_o), 64'd0);
        repeat (3) tick();
        check("plan_nwrites", 64'(got_addr.size()), 64'd2);
        if (got_addr.size() == 2) begin
            check("plan_addr0", 64'(got_addr[0]), 64'h0);
            check("plan_data0", 64'(got_data[0]), 64'h00402103);
            check("plan_addr1", 64'(got_addr[1]), 64'h4);
            check("plan_data1", 64'(got_data[1]), 64'h00400183);
        end

        // Same image with byte_valid toggling every other cycle
        run_session(plan, 1, 1'b0, "gap_plan");

        // Table of length headers
        for (int v = 0; v < 10; v++) begin
            bq_t s;
            s = make_stream(vecs[v].len, 1'b1);
            run_session(s, vecs[v].gap, 1'b0, $sformatf("vec%0d", v));
            check($sformatf("vec%0d_tbl_err", v), 64'(error_o), 64'(vecs[v].exp_err));
            check($sformatf("vec%0d_tbl_words", v), 64'(got_addr.size()), 64'(vecs[v].exp_words));
        end

        // Randomized sessions with gaps and ignored start pulses
        for (int r = 0; r < 30; r++) begin
            bq_t         s;
            logic [15:0] len;
            if ($urandom_range(0, 7) == 0) len = 16'($urandom);
            else len = 16'(4 * $urandom_range(0, 12));
            s = make_stream(len, $urandom_range(0, 3) != 0);
            run_session(s, -1, 1'b1, $sformatf("rnd%0d", r));
        end

        // Reset after five payload bytes
        got_addr.delete();
        got_data.delete();
        do_start();
        for (int i = 0; i < 7; i++) send_byte(plan[i], 0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_ready", 64'(byte_ready_o), 64'd0);
        check("arst_wr_en", 64'(wr_en_o), 64'd0);
        check("arst_wr_addr", 64'(wr_addr_o), 64'd0);
        check("arst_wr_data", 64'(wr_data_o), 64'd0);
        check("arst_busy", 64'(busy_o), 64'd0);
        check("arst_done", 64'(done_o), 64'd0);
        check("arst_error", 64'(error_o), 64'd0);
        check("arst_cpu_hold", 64'(cpu_hold_o), 64'd1);
        repeat (3) tick();
        check("arst_no_more_writes", 64'(got_addr.size()), 64'd1);
        rst_n = 1'b1;
        tick();

        // Start with a valid byte in IDLE: byte must not be taken as len[7:0]
        got_addr.delete();
        got_data.delete();
        byte_d = 8'hFF;
        byte_valid = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        byte_valid = 1'b0;
        check("idle_start_ready", 64'(byte_ready_o), 64'd1);
        send_byte(8'h04, 0, 1'b0);
        send_byte(8'h00, 0, 1'b0);
        send_byte(8'h03, 0, 1'b0);
        send_byte(8'h21, 0, 1'b0);
        send_byte(8'h40, 0, 1'b0);
        send_byte(8'h00, 0, 1'b0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(8'h62, 0, 1'b0);
`endif
        repeat (3) tick();
        check("idle_start_done", 64'(done_o), 64'd1);
        check("idle_start_nwrites", 64'(got_addr.size()), 64'd1);
        if (got_addr.size() == 1) begin
            check("idle_start_addr", 64'(got_addr[0]), 64'h0);
            check("idle_start_data", 64'(got_data[0]), 64'h00402103);
        end

        // Full image after the aborted session loads from address 0
        run_session(plan, 0, 1'b0, "post_rst");

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Checksum mismatch keeps the written word and the CPU hold
        got_addr.delete();
        got_data.delete();
        do_start();
        send_byte(8'h04, 0, 1'b0);
        send_byte(8'h00, 0, 1'b0);
        send_byte(8'h03, 0, 1'b0);
        send_byte(8'h21, 0, 1'b0);
        send_byte(8'h40, 0, 1'b0);
        send_byte(8'h00, 0, 1'b0);
        send_byte(8'h63, 0, 1'b0);
        check("chk_bad_error_edge", 64'(error_o), 64'd1);
        repeat (3) tick();
        check("chk_bad_done", 64'(done_o), 64'd0);
        check("chk_bad_hold", 64'(cpu_hold_o), 64'd1);
        check("chk_bad_nwrites", 64'(got_addr.size()), 64'd1);
        if (got_addr.size() == 1) check("chk_bad_data", 64'(got_data[0]), 64'h00402103);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/imem_loader.md
# imem_loader

Boot-time writer for the byte-addressed instruction memory. Accepts a length-prefixed byte stream over a valid/ready handshake and assembles it into little-endian 32-bit words. Each word is written through a word write port at incrementing word-aligned byte addresses. The CPU is held in reset until a complete image has loaded, so the fetch path only ever sees a complete image.

## Interface

Parameters:
- DEPTH_BYTES, 1024, instruction memory size in bytes; must be a multiple of 4.
- ADDR_WIDTH, 32, width of wr_addr_o.

Ports:
- clk_i  input  1  clock; all state changes on the rising edge.
- rst_n_i  input  1  reset; asynchronous, active-low.
- start_i  input  1  starts a load session; single-cycle pulse.
- byte_i  input  8  stream byte.
- byte_valid_i  input  1  byte_i is valid.
- byte_ready_o  output  1  loader can accept a byte this cycle.
- wr_en_o  output  1  one-cycle word write strobe.
- wr_addr_o  output  ADDR_WIDTH  byte address of the word; always a multiple of 4.
- wr_data_o  output  32  word data; byte at the lowest address is in [7:0].
- busy_o  output  1  a session is in progress.
- done_o  output  1  image loaded; sticky.
- error_o  output  1  session failed; sticky.
- cpu_hold_o  output  1  holds the CPU in reset.

## Operation

- States: IDLE, LEN_LO, LEN_HI, DATA, CHK (only when CHK_EN is defined), DONE, ERR.
- A byte is accepted on a rising edge where byte_valid_i && byte_ready_o.
- byte_ready_o is 1 only in LEN_LO, LEN_HI, DATA and CHK.
- IDLE/DONE/ERR: start_i moves to LEN_LO, clears done_o, error_o and the address, and loads the checksum seed (0x00).
- LEN_LO: accept a byte as len[7:0], then go to LEN_HI.
- LEN_HI: accept a byte as len[15:8], then:
  - len > DEPTH_BYTES or len[1:0] != 0: go to ERR.
  - len == 0: go to CHK if CHK_EN is defined, otherwise DONE.
  - otherwise: go to DATA.
- DATA: bytes fill an assembly register at lane = byte count mod 4.
  - On the 4th accepted byte, the full word is registered to wr_data_o and wr_en_o pulses for one cycle.
  - wr_addr_o holds the current address (starting at 0); the address then increments by 4.
  - After the word that brings the byte count to len, go to CHK or DONE.
- start_i in LEN_LO, LEN_HI, DATA or CHK is ignored.
- busy_o = 1 in LEN_LO, LEN_HI, DATA and CHK.
- cpu_hold_o = 0 only in DONE.
- Byte counter is 16 bits. The address never exceeds DEPTH_BYTES-4, guaranteed by the length check.

## Timing

- Reset values:
  - State IDLE.
  - byte_ready_o=0, wr_en_o=0, wr_addr_o=0, wr_data_o=0.
  - busy_o=0, done_o=0, error_o=0, cpu_hold_o=1.
- Assertion of rst_n_i aborts any session immediately; no further writes occur.
- wr_en_o rises the cycle after the 4th byte of a word is accepted. Address and data are stable during that cycle.
- Throughput is one byte per cycle. byte_ready_o stays 1 during a wr_en_o pulse, so the loader never back-pressures inside DATA.
- Gaps in byte_valid_i stall the loader with no state change.
- done_o rises on the same edge as the last wr_en_o (or on acceptance of the checksum byte). cpu_hold_o falls on that same edge.
- error_o rises on the edge that accepts the offending byte.
- start_i together with a byte in IDLE: the byte is not accepted, because ready is 0 in IDLE.

## Configuration

- IMEM_LOADER_CHECKSUM_EN defined:
  - After the payload, state CHK accepts one extra byte.
  - If it equals the XOR of all payload bytes (seed 0x00), go to DONE; otherwise go to ERR.
  - Words already written remain in memory; cpu_hold_o stays 1.
- Not defined: CHK does not exist, and the stream is exactly 2 + len bytes.

## Test plan

- Reset then start, stream 08 00 03 21 40 00 83 01 40 00 -> writes (0x0, 0x00402103) then (0x4, 0x00400183); done_o=1; cpu_hold_o=0.
- Length 0x0006 -> error_o=1 after the second length byte; no wr_en_o; cpu_hold_o=1.
- Length 0x0404 with DEPTH_BYTES=1024 -> error_o=1.
- Length 0x0000 -> done_o one cycle later with no writes (without the macro).
- 8-byte image with byte_valid_i toggling every other cycle -> same two writes; exactly two wr_en_o pulses.
- rst_n_i asserted after 5 payload bytes:
  - Outputs return to reset values asynchronously.
  - A new start followed by a full stream loads from address 0.
- With IMEM_LOADER_CHECKSUM_EN, payload 03 21 40 00:
  - Checksum byte 0x62 -> done_o=1.
  - Checksum byte 0x63 -> error_o=1 with the word already written.
